// File: rtl/stack_unit.sv
// LIFO operand stack for the multicycle stack CPU.
// Registered read port; sticky overflow/underflow flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [CW-1:0]    count_nxt;
    logic             wr_en;
    logic             rd_en;
    logic             ovf_set;
    logic             unf_set;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign top_idx = AW'(count - 1'b1);

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = AW'(count);
        count_nxt = count;
        rd_en     = (pop || tos) && !empty;
        ovf_set   = push && !pop && full;
        // A pop or tos on an empty stack is only an error when no push rescues it.
        unf_set   = (pop || tos) && empty && !push;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push && !full) begin
            wr_en     = 1'b1;
            count_nxt = count + 1'b1;
        end else if (pop && !push && !empty) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (rd_en) begin
                dout <= mem[top_idx];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: queue-based LIFO model,
// directed scenarios plus biased random traffic.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             tos = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    typedef struct {
        logic [WIDTH-1:0] dout;
        int               count;
        bit               ovf;
        bit               unf;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               stk[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf;
    bit               m_unf;
    int               n_cmp = 0;
    int               n_bad = 0;

    stack_unit #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .tos      (tos),
        .din      (din),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: plain queue semantics evaluated on pre-edge state.
    function automatic void model(bit p, bit o, bit t, logic [WIDTH-1:0] d);
        bit emp;
        emp = (stk.size() == 0);
        if ((o || t) && !emp) m_dout = WIDTH'(stk[stk.size()-1]);
        if (p && o && !emp) begin
            stk[stk.size()-1] = int'(d);
        end else if (p) begin
            if (stk.size() < DEPTH) stk.push_back(int'(d));
            else m_ovf = 1'b1;
        end else if (o) begin
            if (emp) m_unf = 1'b1;
            else void'(stk.pop_back());
        end
        if (t && emp && !p) m_unf = 1'b1;
    endfunction

    function automatic void model_reset();
        stk.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endfunction

    task automatic step(bit p, bit o, bit t, logic [WIDTH-1:0] d);
        exp_t e;
        @(negedge clk);
        push = p;
        pop  = o;
        tos  = t;
        din  = d;
        @(posedge clk);
        model(p, o, t, d);
        e.dout  = m_dout;
        e.count = stk.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        rst  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("dout", 32'(dout), 32'(mon_e.dout));
            chk("count", 32'(count), 32'(mon_e.count));
            chk("empty", 32'(empty), 32'(mon_e.count == 0));
            chk("full", 32'(full), 32'(mon_e.count == DEPTH));
            chk("overflow", 32'(overflow), 32'(mon_e.ovf));
            chk("underflow", 32'(underflow), 32'(mon_e.unf));
        end
    end

    initial begin
        int pb;
        int ob;
        model_reset();
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_flags", 32'({overflow, underflow}), 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (10) step(0, 0, 0, 8'h00);

        // LIFO order
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        repeat (3) step(0, 1, 0, 8'h00);

        // Fill, overflow, pop returns last good entry
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, WIDTH'(i));
        step(1, 0, 0, 8'hFF);
        step(0, 1, 0, 8'h00);

        // Underflow then recovery
        do_reset();
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h5A);
        step(0, 0, 1, 8'h00);

        // Replace on partial and on full stack
        do_reset();
        step(1, 0, 0, 8'h10);
        step(1, 0, 0, 8'h20);
        step(1, 1, 0, 8'h99);
        step(0, 1, 0, 8'h00);
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, WIDTH'(8'hA0 + i));
        step(1, 1, 0, 8'h77);
        step(0, 1, 1, 8'h00);
        step(1, 1, 1, 8'h00);

        // Push+pop and push+tos on empty: push only, no underflow
        do_reset();
        step(1, 1, 0, 8'h3C);
        step(0, 1, 0, 8'h00);
        step(1, 0, 1, 8'h4D);
        step(1, 0, 1, 8'h5E);

        // Async reset between edges
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, WIDTH'(8'hC0 + i));
        step(0, 0, 1, 8'h00);
        #3;
        rst = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_dout", 32'(dout), 0);
        chk("async_empty", 32'(empty), 1);
        model_reset();
        @(negedge clk);
        push = 1'b0;
        tos  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 0, 8'h00);

        // Biased random traffic
        for (int ph = 0; ph < 6; ph++) begin
            do_reset();
            pb = (ph % 2 == 0) ? 65 : 35;
            ob = (ph % 2 == 0) ? 30 : 55;
            for (int n = 0; n < 120; n++) begin
                step(($urandom % 100) < pb, ($urandom % 100) < ob,
                     ($urandom % 100) < 15, WIDTH'($urandom));
            end
        end

        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
